// File: rtl/wb_sram_ctrl.sv
// Wishbone-style slave driving two asynchronous SRAM banks (base, ext) with programmable wait states.
// Define RAM_BYTE_LANE_EN for SRAMs with byte enables; otherwise partial writes use read-modify-write.
module wb_sram_ctrl #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         bus_addr_i,
  input  logic [DATA_W-1:0]   bus_data_i,
  output logic [DATA_W-1:0]   bus_data_o,
  input  logic [DATA_W/8-1:0] bus_sel_i,
  input  logic                bus_select_i,
  input  logic                bus_we_i,
  output logic                bus_ack_o,
  output logic [ADDR_W-1:0]   baseram_addr,
  inout  wire  [DATA_W-1:0]   baseram_data,
  output logic                baseram_ce,
  output logic                baseram_oe,
  output logic                baseram_we,
`ifdef RAM_BYTE_LANE_EN
  output logic [DATA_W/8-1:0] baseram_be,
  output logic [DATA_W/8-1:0] extram_be,
`endif
  output logic [ADDR_W-1:0]   extram_addr,
  inout  wire  [DATA_W-1:0]   extram_data,
  output logic                extram_ce,
  output logic                extram_oe,
  output logic                extram_we
);

  localparam int SEL_W = DATA_W / 8;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR_SETUP, WR_PULSE, WR_HOLD, ACK} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              bank_q;
  logic [ADDR_W-1:0] base_addr_q, ext_addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [SEL_W-1:0]  sel_q;
  logic [1:0]        ce_q, oe_q, we_q;  // bit 0 = base, bit 1 = ext, active-low
  logic              drive_q, ack_q;

  logic              req_bank;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_mask, bank_mask;
  logic [DATA_W-1:0] rd_bus;
  logic              go_rmw;
  logic              unused_addr_bits;

  assign req_bank  = bus_addr_i[ADDR_W+2];
  assign req_addr  = bus_addr_i[ADDR_W+1:2];
  assign req_mask  = req_bank ? 2'b01 : 2'b10;
  assign bank_mask = bank_q ? 2'b01 : 2'b10;
  assign rd_bus    = bank_q ? extram_data : baseram_data;
  assign unused_addr_bits = ^{bus_addr_i[31:ADDR_W+3], bus_addr_i[1:0]};

`ifdef RAM_BYTE_LANE_EN
  assign go_rmw = 1'b0;
`else
  assign go_rmw = (bus_sel_i != {SEL_W{1'b1}});
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bank_q      <= 1'b0;
      base_addr_q <= '0;
      ext_addr_q  <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      sel_q       <= '0;
      ce_q        <= 2'b11;
      oe_q        <= 2'b11;
      we_q        <= 2'b11;
      drive_q     <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus_select_i) begin
            bank_q  <= req_bank;
            wdata_q <= bus_data_i;
            sel_q   <= bus_sel_i;
            cnt_q   <= CNT_LOAD;
            if (req_bank) ext_addr_q <= req_addr;
            else          base_addr_q <= req_addr;
            if (!bus_we_i) begin
              state_q <= RD;
              ce_q    <= req_mask;
              oe_q    <= req_mask;
            end else if (bus_sel_i == '0) begin
              state_q <= ACK;
              ack_q   <= 1'b1;
            end else if (go_rmw) begin
              state_q <= RMW_RD;
              ce_q    <= req_mask;
              oe_q    <= req_mask;
            end else begin
              state_q <= WR_SETUP;
              ce_q    <= req_mask;
              drive_q <= 1'b1;
            end
          end
        end
        RD: begin
          if (cnt_q == '0) begin
            rdata_q <= rd_bus;
            ce_q    <= 2'b11;
            oe_q    <= 2'b11;
            ack_q   <= 1'b1;
            state_q <= ACK;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
`ifndef RAM_BYTE_LANE_EN
        RMW_RD: begin
          if (cnt_q == '0) begin
            for (int i = 0; i < SEL_W; i++) begin
              if (!sel_q[i]) wdata_q[8*i +: 8] <= rd_bus[8*i +: 8];
            end
            oe_q    <= 2'b11;
            drive_q <= 1'b1;
            state_q <= WR_SETUP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
`endif
        WR_SETUP: begin
          we_q    <= bank_mask;
          cnt_q   <= CNT_LOAD;
          state_q <= WR_PULSE;
        end
        WR_PULSE: begin
          if (cnt_q == '0) begin
            we_q    <= 2'b11;
            state_q <= WR_HOLD;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        WR_HOLD: begin
          drive_q <= 1'b0;
          ce_q    <= 2'b11;
          ack_q   <= 1'b1;
          state_q <= ACK;
        end
        ACK:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_data_o   = rdata_q;
  assign bus_ack_o    = ack_q;
  assign baseram_addr = base_addr_q;
  assign extram_addr  = ext_addr_q;
  assign baseram_ce   = ce_q[0];
  assign baseram_oe   = oe_q[0];
  assign baseram_we   = we_q[0];
  assign extram_ce    = ce_q[1];
  assign extram_oe    = oe_q[1];
  assign extram_we    = we_q[1];

  // drive_q is only set while oe is high, so the bus never fights the SRAM
  assign baseram_data = (drive_q && !bank_q) ? wdata_q : {DATA_W{1'bz}};
  assign extram_data  = (drive_q && bank_q)  ? wdata_q : {DATA_W{1'bz}};

`ifdef RAM_BYTE_LANE_EN
  assign baseram_be = (drive_q && !bank_q) ? ~sel_q : '0;
  assign extram_be  = (drive_q && bank_q)  ? ~sel_q : '0;
`endif

endmodule

// File: tb/tb_wb_sram_ctrl.sv
// Bench for wb_sram_ctrl: vector table with a scoreboard queue, behavioural SRAM banks,
// plus hand sequences for dropped requests, back-to-back requests and reset mid-write.
module tb_wb_sram_ctrl;
  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_sel;
  logic        bus_select, bus_we, bus_ack;
  logic [19:0] base_addr, ext_addr;
  wire  [31:0] base_data, ext_data;
  logic        base_ce, base_oe, base_we, ext_ce, ext_oe, ext_we;
  logic [3:0]  base_lane_n, ext_lane_n;

`ifdef RAM_BYTE_LANE_EN
  logic [3:0] base_be, ext_be;
  localparam bit BE = 1'b1;
  assign base_lane_n = base_be;
  assign ext_lane_n  = ext_be;
`else
  localparam bit BE = 1'b0;
  assign base_lane_n = 4'h0;
  assign ext_lane_n  = 4'h0;
`endif

  always #5 clk = ~clk;

  wb_sram_ctrl #(.ADDR_W(20), .DATA_W(32), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .bus_addr_i(bus_addr), .bus_data_i(bus_wdata), .bus_data_o(bus_rdata),
    .bus_sel_i(bus_sel), .bus_select_i(bus_select), .bus_we_i(bus_we), .bus_ack_o(bus_ack),
    .baseram_addr(base_addr), .baseram_data(base_data),
    .baseram_ce(base_ce), .baseram_oe(base_oe), .baseram_we(base_we),
`ifdef RAM_BYTE_LANE_EN
    .baseram_be(base_be), .extram_be(ext_be),
`endif
    .extram_addr(ext_addr), .extram_data(ext_data),
    .extram_ce(ext_ce), .extram_oe(ext_oe), .extram_we(ext_we)
  );

  // Behavioural asynchronous SRAMs (256 words each is enough for the addresses used)
  logic [31:0] base_mem [256] = '{default: 32'h0};
  logic [31:0] ext_mem  [256] = '{default: 32'h0};
  assign base_data = (!base_ce && !base_oe) ? base_mem[base_addr[7:0]] : 'z;
  assign ext_data  = (!ext_ce && !ext_oe)   ? ext_mem[ext_addr[7:0]]   : 'z;
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!base_ce && !base_we && !base_lane_n[i]) base_mem[base_addr[7:0]][8*i +: 8] <= base_data[8*i +: 8];
      if (!ext_ce && !ext_we && !ext_lane_n[i])    ext_mem[ext_addr[7:0]][8*i +: 8]   <= ext_data[8*i +: 8];
    end
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic [31:0] exp_rd;
  } vec_t;

  typedef struct {
    int          lat;
    logic [31:0] rdata;
    int          ce_lo;
    int          oe_lo;
    int          we_lo;
  } exp_t;

  vec_t        vecs [12];
  exp_t        sbq [$];
  logic [31:0] ref_mem [512] = '{default: 32'h0};
  logic [31:0] last_rd;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input bit drop, input string nm);
    exp_t        e, got_e;
    logic        bank;
    logic [8:0]  ridx;
    logic [31:0] mem_now;
    logic [3:0]  be_seen;
    int cyc, ce_lo, oe_lo, we_lo, other_ce, both_lo;
    bit got;
    bank = v.addr[22];
    ridx = {bank, v.addr[9:2]};
    if (!v.we) begin
      e.lat = W + 1;     e.ce_lo = W;         e.oe_lo = W; e.we_lo = 0;
    end else if (v.sel == 4'h0) begin
      e.lat = 1;         e.ce_lo = 0;         e.oe_lo = 0; e.we_lo = 0;
    end else if (v.sel == 4'hF || BE) begin
      e.lat = W + 3;     e.ce_lo = W + 2;     e.oe_lo = 0; e.we_lo = W;
    end else begin
      e.lat = 2 * W + 3; e.ce_lo = 2 * W + 2; e.oe_lo = W; e.we_lo = W;
    end
    e.rdata = v.we ? last_rd : v.exp_rd;
    sbq.push_back(e);

    bus_addr = v.addr; bus_wdata = v.data; bus_sel = v.sel; bus_we = v.we; bus_select = 1'b1;
    cyc = 0; got = 0; ce_lo = 0; oe_lo = 0; we_lo = 0; other_ce = 0; both_lo = 0; be_seen = 4'h0;
    while (!got && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (drop) begin
        bus_select = 1'b0; bus_we = ~v.we; bus_addr = 32'hFFFF_FFFC; bus_sel = 4'h0;
      end
      if (bank ? !ext_ce : !base_ce) ce_lo++;
      if (bank ? !ext_oe : !base_oe) oe_lo++;
      if (bank ? !ext_we : !base_we) we_lo++;
      if (bank ? !base_ce : !ext_ce) other_ce++;
      if ((!base_oe && !base_we) || (!ext_oe && !ext_we)) both_lo++;
`ifdef RAM_BYTE_LANE_EN
      if (bank ? !ext_we : !base_we) be_seen = bank ? ext_be : base_be;
`endif
      if (bus_ack) got = 1;
    end
    chk({nm, " ack"}, 32'(got), 32'd1);
    got_e = sbq.pop_front();
    chk({nm, " latency"}, cyc, got_e.lat);
    chk({nm, " rdata"}, bus_rdata, got_e.rdata);
    chk({nm, " ce_low"}, ce_lo, got_e.ce_lo);
    chk({nm, " oe_low"}, oe_lo, got_e.oe_lo);
    chk({nm, " we_low"}, we_lo, got_e.we_lo);
    chk({nm, " other_ce"}, other_ce, 0);
    chk({nm, " oe_we_overlap"}, both_lo, 0);
    chk({nm, " bank_addr"}, 32'(bank ? ext_addr : base_addr), 32'(v.addr[21:2]));
`ifdef RAM_BYTE_LANE_EN
    if (v.we && v.sel != 4'h0) chk({nm, " be"}, 32'(be_seen), 32'(~v.sel));
`endif
    bus_select = 1'b0;
    @(posedge clk); #1;
    chk({nm, " ack_one_cycle"}, 32'(bus_ack), 32'd0);

    if (v.we) begin
      for (int i = 0; i < 4; i++) if (v.sel[i]) ref_mem[ridx][8*i +: 8] = v.data[8*i +: 8];
      mem_now = bank ? ext_mem[v.addr[9:2]] : base_mem[v.addr[9:2]];
      chk({nm, " sram_word"}, mem_now, ref_mem[ridx]);
    end else begin
      last_rd = v.exp_rd;
    end
  endtask

  initial begin : main
    int cyc, acks, a1, a2, both;
    bit idle_ok;
    vec_t d;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h0040_0000, 32'h1234_5678, 4'hF, 32'h0};
    vecs[3]  = '{1'b0, 32'h0000_0000, 32'h0,         4'hF, 32'h0};
    vecs[4]  = '{1'b0, 32'h0040_0000, 32'h0,         4'hF, 32'h1234_5678};
    vecs[5]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'hF, 32'h0};
    vecs[6]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'h5, 32'h0};
    vecs[7]  = '{1'b0, 32'h8000_0023, 32'h0,         4'hF, 32'hAA22_CC44};
    vecs[8]  = '{1'b1, 32'h0000_0030, 32'h9999_9999, 4'h0, 32'h0};
    vecs[9]  = '{1'b1, 32'h0040_0004, 32'hFFEE_DDCC, 4'h8, 32'h0};
    vecs[10] = '{1'b0, 32'h0040_0004, 32'h0,         4'hF, 32'hFF00_0000};
    vecs[11] = '{1'b0, 32'hFFC0_0000, 32'h0,         4'hF, 32'h1234_5678};

    rst = 1'b1; bus_addr = '0; bus_wdata = '0; bus_sel = '0; bus_we = 1'b0; bus_select = 1'b0;
    last_rd = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ack", 32'(bus_ack), 32'd0);
    chk("reset rdata", bus_rdata, 32'h0);
    chk("reset strobes", 32'({base_ce, base_oe, base_we, ext_ce, ext_oe, ext_we}), 32'h3F);
    chk("reset addrs", 32'({base_addr, ext_addr}), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) run_txn(vecs[i], 1'b0, $sformatf("v%0d", i));

    // request dropped right after acceptance; we/addr/sel changes must be ignored
    d = '{1'b0, 32'h0000_0010, 32'h0, 4'hF, 32'hDEAD_BEEF};
    run_txn(d, 1'b1, "drop_rd");
    d = '{1'b1, 32'h0000_0044, 32'hCAFE_F00D, 4'hF, 32'h0};
    run_txn(d, 1'b1, "drop_wr");

    // back-to-back reads with select held high across the ack
    bus_addr = 32'h0000_0010; bus_we = 1'b0; bus_sel = 4'hF; bus_select = 1'b1;
    cyc = 0; acks = 0; a1 = 0; a2 = 0; both = 0; idle_ok = 1'b0;
    while (cyc < 60 && !(acks >= 2 && cyc >= a2 + 4)) begin
      @(posedge clk); #1;
      cyc++;
      if ((!base_oe && !base_we) || (!ext_oe && !ext_we)) both++;
      if (acks == 1 && cyc == a1 + 1) idle_ok = base_ce && ext_ce && !bus_ack;
      if (bus_ack) begin
        acks++;
        if (acks == 1) a1 = cyc;
        else if (acks == 2) begin
          a2 = cyc;
          bus_select = 1'b0;
        end
      end
    end
    chk("b2b acks", acks, 2);
    chk("b2b first", a1, W + 1);
    chk("b2b gap", a2 - a1, W + 2);
    chk("b2b idle", 32'(idle_ok), 32'd1);
    chk("b2b overlap", both, 0);
    chk("b2b rdata", bus_rdata, 32'hDEAD_BEEF);

    // reset during the first WR_PULSE cycle
    bus_addr = 32'h0000_0040; bus_we = 1'b1; bus_wdata = 32'h55AA_55AA; bus_sel = 4'hF; bus_select = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstmid pulse_we", 32'(base_we), 32'd0);
    rst = 1'b1; bus_select = 1'b0;
    @(posedge clk); #1;
    chk("rstmid we", 32'({base_we, ext_we}), 32'h3);
    chk("rstmid ce", 32'({base_ce, ext_ce}), 32'h3);
    chk("rstmid oe", 32'({base_oe, ext_oe}), 32'h3);
    chk("rstmid ack", 32'(bus_ack), 32'd0);
    chk("rstmid rdata", bus_rdata, 32'h0);
    chk("rstmid addr", 32'({base_addr, ext_addr}), 32'h0);
    last_rd = 32'h0;
    rst = 1'b0;
    acks = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus_ack) acks++;
    end
    chk("rstmid no_ack", acks, 0);

    d = '{1'b0, 32'h0000_0010, 32'h0, 4'hF, 32'hDEAD_BEEF};
    run_txn(d, 1'b0, "post_rst_rd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_sram_ctrl.md
Name: wb_sram_ctrl

Overview:
- Wishbone-style slave bridging the system bus to two asynchronous 32-bit SRAM banks: base and ext.
- Replaces the fixed-timing RAM wrapper.
- Generalised in bank depth, data width and access wait states.
- Adds byte-select writes (read-modify-write when the SRAM has no byte lanes), registered read data and a single-cycle ack handshake.
- Sits between the bus arbiter and the board SRAM pins.

Parameters:
- ADDR_W, 20: word-address width of each bank. Total space is 2^(ADDR_W+1) words.
- DATA_W, 32: data width. Must be a multiple of 8. SEL_W = DATA_W/8.
- WAIT_CYCLES, 2: SRAM access/pulse width in clk cycles, at least 1.

Ports:
- clk in 1: clock.
- rst in 1: synchronous, active-high reset.
- bus_addr_i in 32: byte address.
- bus_data_i in DATA_W: write data.
- bus_data_o out DATA_W: read data, registered.
- bus_sel_i in SEL_W: byte-lane enables.
- bus_select_i in 1: cycle request. Held by the master until ack.
- bus_we_i in 1: 1 = write, 0 = read.
- bus_ack_o out 1: one-cycle completion pulse.
- baseram_addr out ADDR_W: base bank word address.
- baseram_data inout DATA_W: base bank data.
- baseram_ce out 1: base bank chip enable, active-low.
- baseram_oe out 1: base bank output enable, active-low.
- baseram_we out 1: base bank write enable, active-low.
- extram_addr out ADDR_W: ext bank word address.
- extram_data inout DATA_W: ext bank data.
- extram_ce, extram_oe, extram_we out 1 each: same as the base bank, active-low.

Behaviour:
- Reset, synchronous, takes effect at the next clk edge even mid-transaction:
  - state = IDLE, bus_ack_o = 0, bus_data_o = 0.
  - All ce/oe/we = 1; both data buses high-Z; addresses = 0.
  - Any partial SRAM write is aborted: we rises at that edge.
- Address decode:
  - word = bus_addr_i[ADDR_W+2:2]; bank = bit ADDR_W+2 (0 = base, 1 = ext); bank address = bus_addr_i[ADDR_W+1:2].
  - Bits above ADDR_W+2 and bits [1:0] are ignored (aliasing).
- Address, data and sel are latched in IDLE when the request is accepted and held for the whole transaction.
- Only the selected bank sees ce = 0. The other bank stays deselected and high-Z.
- States: IDLE, RD, RMW_RD, WR_SETUP, WR_PULSE, WR_HOLD, ACK.
- IDLE:
  - If bus_select_i = 1 at edge k: read → RD. Write with all sel bits set → WR_SETUP. Write with partial sel → RMW_RD.
  - sel = 0 on a write: no SRAM access; go straight to ACK.
- RD / RMW_RD:
  - ce = 0, oe = 0 for WAIT_CYCLES cycles, counted by a down-counter.
  - On the last cycle: RD captures SRAM data into bus_data_o; RMW_RD merges unselected lanes from SRAM with selected lanes from write data.
  - RD → ACK. RMW_RD → WR_SETUP.
- WR_SETUP (1 cycle): ce = 0, oe = 1, we = 1, data driven.
- WR_PULSE (WAIT_CYCLES cycles): we = 0, data driven.
- WR_HOLD (1 cycle): we = 1, data still driven. Then → ACK.
- Data bus is driven only in WR_SETUP, WR_PULSE and WR_HOLD. It is high-Z in every other state. It is never driven while oe = 0.
- ACK:
  - bus_ack_o = 1 for exactly one cycle; all strobes inactive; → IDLE.
  - bus_data_o holds its value until the next read capture. Writes leave it unchanged.
- Latency, with the request sampled at edge k and W = WAIT_CYCLES:
  - Read: ack high during cycle k+W+1.
  - Full write: ack during cycle k+W+3.
  - Partial write: ack during cycle k+2W+3.
- Request handling:
  - bus_select_i is not re-sampled until IDLE, so back-to-back requests get one IDLE cycle between them.
  - A request dropped mid-transaction is still completed and acked.
  - Changes to bus_we_i/addr after acceptance are ignored.

Optional Feature:
- Macro: RAM_BYTE_LANE_EN.
- When defined:
  - Adds ports baseram_be and extram_be, out SEL_W, active-low byte enables, driven as ~sel during writes and 0 during reads.
  - Partial writes go IDLE → WR_SETUP directly. RMW_RD is unreachable and not synthesised.
  - Partial-write latency equals full-write latency.
- When undefined: no be ports; partial writes use read-modify-write as above.

Test Plan:
- Reset mid-WR_PULSE: rst at WR_PULSE cycle 1 → next cycle we = 1, ce = 1, buses high-Z, ack never asserted.
- Full write then read, W = 2: write 0xDEADBEEF to 0x0000_0010, sel = 0xF → ack at k+5, base addr = 4, ext ce = 1 throughout. Read from the same address → ack at k+3, bus_data_o = 0xDEADBEEF.
- Bank select, ADDR_W = 20: write 0x12345678 to 0x0040_0000 → ext addr = 0, base ce stays 1. Read from 0x0000_0000 returns the untouched base content.
- Partial write, no macro: base word = 0xAABBCCDD, write 0x11223344 with sel = 0x5 → ack at k+7, SRAM word = 0xAA22CC44, oe = 0 only in RMW_RD.
- Partial write with RAM_BYTE_LANE_EN: same stimulus → ack at k+5, be = 0xA during WR_PULSE, no oe assertion.
- Back-to-back requests with bus_select_i held high across ack: exactly one ack per transaction, one IDLE cycle between them, data bus never driven while oe = 0.
